light_zone_scheduler: RTL and testbench
=======================================

# light_zone_scheduler

Controller that owns the lamp outputs for several lighting zones. It takes single-cycle toggle pulses from each zone's synchronizer and level-to-pulse front end, and services them one per cycle in round-robin order. It also enforces a limit on how many lamps may be on at once and turns each lamp off automatically after a timeout. It sits between the per-switch pulse front ends and the lamp drivers, in the divided 1 MHz clock domain.

## Interface
- NZ, 4, number of zones (2..8)
- MAX_ON, 2, maximum lamps simultaneously on (1..NZ)
- TICK_DIV, 1000, clk_1Mhz cycles per timer tick (≥2)
- TIMEOUT, 600, ticks a lamp stays on before auto-off (≥1)
- clk_1Mhz  in  1  block clock; all state updates on its rising edge
- reset  in  1  reset, synchronous, active-high; clock clk_1Mhz
- toggle_req  in  NZ  per-zone one-cycle toggle pulses, already synchronous to clk_1Mhz
- master_off  in  1  level; while high, forces all lamps off and flushes requests
- lamp_on  out  NZ  registered lamp state per zone
- deny  out  1  registered one-cycle pulse: a turn-on request was refused by the MAX_ON limit
- on_count  out  $clog2(NZ+1)  number of set lamp_on bits (combinational popcount of lamp_on)
- busy  out  1  registered; high while any request is pending

## Operation
- Reset values: lamp_on=0, deny=0, busy=0, pending=0, rr pointer=0, prescaler=0, all zone timers=0.
- Request vector: req = pending | toggle_req.
- Arbiter:
  - Each cycle, scan req starting at the rr pointer, ascending with wrap NZ-1→0.
  - The first set bit is the served zone z. At most one zone is served per cycle.
  - Update pending_next = req & ~onehot(z) and ptr_next = (z+1) mod NZ.
  - If req is 0, the pointer holds.
- Servicing zone z:
  - If lamp_on[z]=1: clear lamp_on[z] and clear timer[z].
  - Else if on_count < MAX_ON: set lamp_on[z] and load timer[z]=TIMEOUT.
  - Else: lamp stays off and deny pulses high for one cycle.
  - The request is consumed in every case; a denied request is not retried.
- Repeated pulses: a new toggle_req on a zone that is already pending merges into the single pending bit. Pulses do not accumulate.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted in the cycle when the count equals TICK_DIV-1.
- Timers:
  - On tick, each timer[z] with lamp_on[z]=1 and timer>0 decrements.
  - Expiry: when timer[z]=1 and tick, lamp_on[z] clears at that edge.
- Simultaneous events:
  - Expiry and service of the same zone in one cycle: lamp ends off and the request is consumed. A turn-off is never re-interpreted as a turn-on.
  - The MAX_ON check uses lamp_on before that cycle's expiries. A lamp freed this cycle is not credited until the next cycle.
- master_off has highest priority. In any cycle it is high:
  - lamp_on, pending and all timers clear, and deny=0.
  - toggle_req in that cycle is discarded.
  - The rr pointer and prescaler keep running.
- busy_next = |pending_next (0 during master_off).
- Reset mid-operation returns all state to reset values at the next edge, regardless of pending or master_off.

## Timing
- Uncontested pulse on zone z in cycle t: lamp_on[z] or deny changes at the edge ending cycle t (1-cycle latency).
- Contended requests: worst-case latency is NZ cycles after the pulse.
- deny is high for exactly one cycle, aligned with the cycle in which lamp_on would have changed.
- Auto-off occurs between (TIMEOUT-1)·TICK_DIV+1 and TIMEOUT·TICK_DIV cycles after turn-on. The exact value depends on prescaler phase.
- on_count follows lamp_on in the same cycle, with no extra latency.

## Test plan
All scenarios use NZ=4, MAX_ON=2, TICK_DIV=10, TIMEOUT=3.
- **Reset:** reset high for 3 cycles with random toggle_req, then release → lamp_on=0000, deny=0, busy=0, on_count=0. One pulse on zone 1 → lamp_on=0010 after 1 cycle.
- **Round-robin contention:** toggle_req=1111 in one cycle at ptr=0 → lamps set in order 0 then 1 on consecutive edges. Zones 2 and 3 each produce a deny pulse on the next two edges. Final lamp_on=0011, busy low after 4 cycles, ptr=0.
- **Toggle off and credit:** lamp_on=0011, pulse zone 0 then zone 2 on the next cycle → lamp_on=0010, then 0110, with no deny.
- **Auto-off:** turn on zone 3 and hold inputs idle → lamp_on[3] clears 21–30 cycles after turn-on, on a tick edge. Expiry coinciding with a zone-3 pulse → lamp stays off and busy clears.
- **master_off:** with lamp_on=0101 and pending on zone 1, assert master_off for 1 cycle together with a toggle_req on zone 3 → lamp_on=0000, busy=0, deny=0. Nothing turns on afterwards.
- **Pulse merge:** pulse zone 2 twice while zones 0 and 1 are being serviced → zone 2 is served exactly once and lamp_on[2] ends set.

Source files
------------

// File: rtl/light_zone_scheduler_if.sv
// -----------------------------------------------------------------------------
// light_zone_scheduler_if
//
// Bundles the request and lamp signals of the lighting-zone scheduler.
//   master : the side that drives toggle requests and master_off
//            (the per-switch front ends or a bench) and reads lamp status.
//   slave  : the scheduler itself.
//
// Signals
//   toggle_req [NZ]          one-cycle toggle pulse per zone
//   master_off               level, forces every lamp off while high
//   lamp_on    [NZ]          registered lamp state per zone
//   deny                     one-cycle pulse, a turn-on was refused by the limit
//   on_count   [clog2(NZ+1)] number of lamps currently on
//   busy                     a request is still waiting for service
// -----------------------------------------------------------------------------
interface light_zone_scheduler_if #(
  parameter int NZ = 4
) ();

  logic [NZ-1:0]           toggle_req;
  logic                    master_off;
  logic [NZ-1:0]           lamp_on;
  logic                    deny;
  logic [$clog2(NZ+1)-1:0] on_count;
  logic                    busy;

  modport master (
    output toggle_req,
    output master_off,
    input  lamp_on,
    input  deny,
    input  on_count,
    input  busy
  );

  modport slave (
    input  toggle_req,
    input  master_off,
    output lamp_on,
    output deny,
    output on_count,
    output busy
  );

endinterface

// File: rtl/light_zone_scheduler.sv
// -----------------------------------------------------------------------------
// light_zone_scheduler
//
// Owns the lamp outputs of NZ lighting zones. Toggle pulses are merged into
// a pending vector and served one zone per cycle in round-robin order. No
// more than MAX_ON lamps may be on at once; a turn-on beyond that limit is
// refused with a one-cycle deny pulse. Each lamp turns itself off after
// TIMEOUT prescaler ticks, one tick every TICK_DIV clock cycles.
//
// Ports
//   clk_1Mhz  clock, all state updates on the rising edge
//   reset     synchronous, active-high reset
//   bus       light_zone_scheduler_if.slave
//             toggle_req, master_off in; lamp_on, deny, on_count, busy out
// -----------------------------------------------------------------------------
module light_zone_scheduler #(
  parameter int NZ       = 4,
  parameter int MAX_ON   = 2,
  parameter int TICK_DIV = 1000,
  parameter int TIMEOUT  = 600
) (
  input  logic                   clk_1Mhz,
  input  logic                   reset,
  light_zone_scheduler_if.slave  bus
);

  localparam int PW = $clog2(NZ);
  localparam int CW = $clog2(NZ + 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Number of set bits in a zone vector.
  function automatic logic [CW-1:0] popcount(input logic [NZ-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < NZ; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Registered state
  logic [NZ-1:0] lamp_r;
  logic [NZ-1:0] pending_r;
  logic          deny_r;
  logic          busy_r;
  logic [PW-1:0] ptr_r;
  logic [DW-1:0] presc_r;
  logic [TW-1:0] timer_r [NZ];

  // Next-state values
  logic [NZ-1:0] lamp_nx_s;
  logic [NZ-1:0] pending_nx_s;
  logic          deny_nx_s;
  logic          busy_nx_s;
  logic [PW-1:0] ptr_nx_s;
  logic [DW-1:0] presc_nx_s;
  logic [TW-1:0] timer_nx_s [NZ];

  // Arbitration and helpers
  logic [NZ-1:0] req_s;
  logic          found_s;
  logic [PW-1:0] served_s;
  logic [NZ-1:0] served_oh_s;
  logic          tick_s;
  logic [CW-1:0] on_count_s;

  assign on_count_s = popcount(lamp_r);
  assign tick_s     = (presc_r == DW'(TICK_DIV - 1));

  // Round-robin scan of the request vector starting at the pointer.
  always_comb begin : arb_scan
    logic [PW-1:0] idx;
    idx      = {PW{1'b0}};
    req_s    = pending_r | bus.toggle_req;
    found_s  = 1'b0;
    served_s = {PW{1'b0}};
    for (int i = 0; i < NZ; i++) begin
      idx = PW'((int'(ptr_r) + i) % NZ);
      if (!found_s && req_s[idx]) begin
        found_s  = 1'b1;
        served_s = idx;
      end else begin
        found_s  = found_s;
        served_s = served_s;
      end
    end
    if (found_s) begin
      served_oh_s = {{(NZ-1){1'b0}}, 1'b1} << served_s;
    end else begin
      served_oh_s = {NZ{1'b0}};
    end
  end

  // Next-state computation: timers, service of the selected zone, master_off.
  always_comb begin
    lamp_nx_s    = lamp_r;
    timer_nx_s   = timer_r;
    deny_nx_s    = 1'b0;
    pending_nx_s = req_s & ~served_oh_s;

    if (found_s) begin
      if (served_s == PW'(NZ - 1)) begin
        ptr_nx_s = {PW{1'b0}};
      end else begin
        ptr_nx_s = served_s + PW'(1);
      end
    end else begin
      ptr_nx_s = ptr_r;
    end

    if (tick_s) begin
      presc_nx_s = {DW{1'b0}};
    end else begin
      presc_nx_s = presc_r + DW'(1);
    end

    // Timer countdown; a timer reaching zero on a tick switches its lamp off.
    for (int z = 0; z < NZ; z++) begin
      if (tick_s && lamp_r[z] && (timer_r[z] != {TW{1'b0}})) begin
        timer_nx_s[z] = timer_r[z] - TW'(1);
        if (timer_r[z] == TW'(1)) begin
          lamp_nx_s[z] = 1'b0;
        end else begin
          lamp_nx_s[z] = lamp_r[z];
        end
      end else begin
        timer_nx_s[z] = timer_r[z];
      end
    end

    // Service decisions look at lamp_r (pre-expiry), so a lamp expiring in
    // this cycle is still a turn-off and its slot is not yet free for others.
    if (found_s) begin
      if (lamp_r[served_s]) begin
        lamp_nx_s[served_s]  = 1'b0;
        timer_nx_s[served_s] = {TW{1'b0}};
      end else if (on_count_s < CW'(MAX_ON)) begin
        lamp_nx_s[served_s]  = 1'b1;
        timer_nx_s[served_s] = TW'(TIMEOUT);
      end else begin
        deny_nx_s = 1'b1;
      end
    end else begin
      deny_nx_s = 1'b0;
    end

    // master_off overrides everything except the pointer and prescaler.
    if (bus.master_off) begin
      lamp_nx_s    = {NZ{1'b0}};
      pending_nx_s = {NZ{1'b0}};
      deny_nx_s    = 1'b0;
      for (int z = 0; z < NZ; z++) begin
        timer_nx_s[z] = {TW{1'b0}};
      end
    end else begin
      pending_nx_s = pending_nx_s;
    end

    busy_nx_s = |pending_nx_s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_1Mhz) begin
    if (reset) begin
      lamp_r    <= {NZ{1'b0}};
      pending_r <= {NZ{1'b0}};
      deny_r    <= 1'b0;
      busy_r    <= 1'b0;
      ptr_r     <= {PW{1'b0}};
      presc_r   <= {DW{1'b0}};
      for (int z = 0; z < NZ; z++) begin
        timer_r[z] <= {TW{1'b0}};
      end
    end else begin
      lamp_r    <= lamp_nx_s;
      pending_r <= pending_nx_s;
      deny_r    <= deny_nx_s;
      busy_r    <= busy_nx_s;
      ptr_r     <= ptr_nx_s;
      presc_r   <= presc_nx_s;
      for (int z = 0; z < NZ; z++) begin
        timer_r[z] <= timer_nx_s[z];
      end
    end
  end

  assign bus.lamp_on  = lamp_r;
  assign bus.deny     = deny_r;
  assign bus.busy     = busy_r;
  assign bus.on_count = on_count_s;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// -----------------------------------------------------------------------------
// tb_light_zone_scheduler
//
// Directed bench for light_zone_scheduler with NZ=4, MAX_ON=2, TICK_DIV=10,
// TIMEOUT=3. Each directed cycle pushes its expected lamp/deny/busy/on_count
// into a scoreboard queue, the clock edge is applied, and the entry is popped
// and compared one time unit after the edge. edge_cnt counts edges since the
// last reset edge, which fixes the prescaler phase (tick edges are multiples
// of 10).
// -----------------------------------------------------------------------------
module tb_light_zone_scheduler;

  logic clk;
  logic reset;

  light_zone_scheduler_if #(.NZ(4)) lz ();

  light_zone_scheduler #(
    .NZ       (4),
    .MAX_ON   (2),
    .TICK_DIV (10),
    .TIMEOUT  (3)
  ) dut (
    .clk_1Mhz (clk),
    .reset    (reset),
    .bus      (lz)
  );

  typedef struct packed {
    logic [3:0] lamp;
    logic       deny;
    logic       busy;
    logic [2:0] cnt;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and step past the rising edge.
  task automatic tick_edge(input logic rst, input logic [3:0] tg, input logic mo);
    @(negedge clk);
    reset         = rst;
    lz.toggle_req = tg;
    lz.master_off = mo;
    @(posedge clk);
    #1;
    edge_cnt++;
    lz.toggle_req = 4'b0000;
    lz.master_off = 1'b0;
  endtask

  task automatic do_cycle(input string tag, input logic rst, input logic [3:0] tg,
                          input logic mo, input logic [3:0] e_lamp,
                          input logic e_deny, input logic e_busy);
    exp_t  e;
    string t;
    e.lamp = e_lamp;
    e.deny = e_deny;
    e.busy = e_busy;
    e.cnt  = 3'($countones(e_lamp));
    sb_q.push_back(e);
    tag_q.push_back(tag);
    tick_edge(rst, tg, mo);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".lamp"},  8'(lz.lamp_on),  8'(e.lamp));
    check({t, ".deny"},  8'(lz.deny),     8'(e.deny));
    check({t, ".busy"},  8'(lz.busy),     8'(e.busy));
    check({t, ".count"}, 8'(lz.on_count), 8'(e.cnt));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    int  on_edge;
    int  clr_edge;
    logic cleared;

    reset         = 1'b1;
    lz.toggle_req = 4'b0000;
    lz.master_off = 1'b0;

    // Reset held for three cycles with random requests.
    tick_edge(1'b1, 4'($urandom_range(15)), 1'b0);
    tick_edge(1'b1, 4'($urandom_range(15)), 1'b0);
    do_cycle("rst", 1'b1, 4'($urandom_range(15)), 1'b0, 4'b0000, 1'b0, 1'b0);
    edge_cnt = 0;

    do_cycle("z1_on",  1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0);  // edge 1
    do_cycle("z1_off", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    do_cycle("z3_on",  1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0);
    do_cycle("z3_off", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);  // ptr back at 0

    // Round-robin contention.
    do_cycle("rr_all",     1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1);  // edge 5
    do_cycle("rr_z1",      1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1);
    do_cycle("rr_z2_deny", 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b1);
    do_cycle("rr_z3_deny", 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0);
    do_cycle("rr_idle",    1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0);

    // Toggle off then credit the freed slot.
    do_cycle("off_z0",    1'b0, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);  // edge 10
    do_cycle("credit_z2", 1'b0, 4'b0100, 1'b0, 4'b0110, 1'b0, 1'b0);
    do_cycle("free_z1",   1'b0, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);
    do_cycle("free_z2",   1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Auto-off of zone 3.
    do_cycle("ao_on", 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0);     // edge 14
    on_edge  = edge_cnt;
    clr_edge = 0;
    cleared  = 1'b0;
    for (int i = 0; i < 40 && !cleared; i++) begin
      tick_edge(1'b0, 4'b0000, 1'b0);
      if (lz.lamp_on[3] == 1'b0) begin
        cleared  = 1'b1;
        clr_edge = edge_cnt;
      end
    end
    check("ao_cleared",   8'(cleared), 8'd1);
    check("ao_range",     8'((clr_edge - on_edge >= 21) && (clr_edge - on_edge <= 30)), 8'd1);
    check("ao_tick_edge", 8'((clr_edge % 10) == 0), 8'd1);
    check("ao_lamps",     8'(lz.lamp_on), 8'h00);

    // Expiry coinciding with a zone-3 pulse (expected expiry at edge 70).
    do_cycle("exp_on", 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0);    // edge 41
    repeat (28) do_cycle("exp_hold", 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    do_cycle("exp_pulse", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); // edge 70
    do_cycle("exp_after", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // master_off with lamps 0101 and zone 1 pending.
    do_cycle("mo_z0",     1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    do_cycle("mo_z2",     1'b0, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b0);
    do_cycle("mo_pend",   1'b0, 4'b1010, 1'b0, 4'b0101, 1'b1, 1'b1);
    do_cycle("mo_assert", 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);
    do_cycle("mo_after",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    do_cycle("mo_after2", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Realign the pointer to 0 (single request each, so order-independent).
    do_cycle("al_on",  1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0);
    do_cycle("al_off", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Pulse merge: zone 2 pulsed twice while zones 0 and 1 are turned off.
    do_cycle("mg_z0",     1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    do_cycle("mg_z1",     1'b0, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
    do_cycle("mg_z3",     1'b0, 4'b1000, 1'b0, 4'b0011, 1'b1, 1'b0);
    do_cycle("mg_p1",     1'b0, 4'b0111, 1'b0, 4'b0010, 1'b0, 1'b1);
    do_cycle("mg_p2",     1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1);
    do_cycle("mg_serve",  1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0);
    do_cycle("mg_stable", 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0);

    // Reset in the middle of operation.
    do_cycle("rst_mid", 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    do_cycle("rst_rel", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
